// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared screen geometry constants and scan state type
package screen_pkg;

  localparam int SCREEN_WORDS_PER_LINE = 32;
  localparam int SCREEN_LINES          = 256;
  localparam int SCREEN_ADDR_W         = 13;
  localparam int SCREEN_BASE           = 16384;
  localparam int SCREEN_PIX_PER_WORD   = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT
  } screen_state_e;

endpackage

// File: rtl/pixel_serializer.sv
// rtl/pixel_serializer.sv - 16-bit word to pixel shifter, LSB first, with bit counter
module pixel_serializer
  import screen_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           load,
  input  logic [SCREEN_PIX_PER_WORD-1:0] data,
  input  logic                           advance,
  output logic                           bit_out,
  output logic                           first,
  output logic                           last
);

  localparam int CNT_W = $clog2(SCREEN_PIX_PER_WORD);

  logic [SCREEN_PIX_PER_WORD-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;

  // A load wins over a shift so a new word can enter on the same edge bit 15 leaves.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = data;
      cnt_d   = '0;
    end else if (advance) begin
      shreg_d = {1'b0, shreg_q[SCREEN_PIX_PER_WORD-1:1]};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_out = shreg_q[0];
  assign first   = (cnt_q == '0);
  assign last    = (cnt_q == CNT_W'(SCREEN_PIX_PER_WORD - 1));

endmodule

// File: rtl/screen_reader.sv
// rtl/screen_reader.sv - screen bitmap scanner; SCREEN_READER_PREFETCH_EN overlaps the next word fetch with shifting
module screen_reader
  import screen_pkg::*;
#(
  parameter int WORDS_PER_LINE = SCREEN_WORDS_PER_LINE,
  parameter int LINES          = SCREEN_LINES,
  parameter int ADDR_W         = SCREEN_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              mem_valid,
  output logic              pix,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              line_start,
  output logic              frame_start
);

  localparam int                TOTAL     = WORDS_PER_LINE * LINES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  screen_state_e     state_q, state_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] shift_word_q, shift_word_d;
  logic              pix_valid_q, pix_valid_d;
`ifdef SCREEN_READER_PREFETCH_EN
  logic [15:0]       hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
`endif

  logic        load;
  logic [15:0] load_data;
  logic        advance, rd_done, frame_end;
  logic        ser_bit, ser_first, ser_last;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  assign advance   = pix_valid_q && pix_ready;
  assign rd_done   = mem_rd_q && mem_valid;
  assign frame_end = (shift_word_q == LAST_ADDR);

  always_comb begin
    state_d      = state_q;
    mem_rd_d     = mem_rd_q;
    fetch_addr_d = fetch_addr_q;
    shift_word_d = shift_word_q;
    pix_valid_d  = pix_valid_q;
    load         = 1'b0;
    load_data    = mem_data;
`ifdef SCREEN_READER_PREFETCH_EN
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d      = FETCH;
          mem_rd_d     = 1'b1;
          fetch_addr_d = '0;
        end
      end
      FETCH: begin
        if (rd_done) begin
          load         = 1'b1;
          mem_rd_d     = 1'b0;
          pix_valid_d  = 1'b1;
          shift_word_d = fetch_addr_q;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
`ifdef SCREEN_READER_PREFETCH_EN
        if (rd_done && !(advance && ser_last)) begin
          hold_d       = mem_data;
          hold_valid_d = 1'b1;
          mem_rd_d     = 1'b0;
        end
        // Wrapping into the next frame is only prefetched while scanning stays enabled.
        if (advance && ser_first && (!frame_end || enable)) begin
          mem_rd_d     = 1'b1;
          fetch_addr_d = next_addr(fetch_addr_q);
        end
        if (advance && ser_last) begin
          if (hold_valid_q) begin
            load         = 1'b1;
            load_data    = hold_q;
            hold_valid_d = 1'b0;
            shift_word_d = fetch_addr_q;
          end else if (rd_done) begin
            load         = 1'b1;
            mem_rd_d     = 1'b0;
            shift_word_d = fetch_addr_q;
          end else if (mem_rd_q) begin
            pix_valid_d = 1'b0;
            state_d     = FETCH;
          end else begin
            pix_valid_d  = 1'b0;
            fetch_addr_d = '0;
            state_d      = IDLE;
          end
        end
`else
        if (advance && ser_last) begin
          pix_valid_d  = 1'b0;
          fetch_addr_d = next_addr(fetch_addr_q);
          if (frame_end && !enable) begin
            state_d = IDLE;
          end else begin
            state_d  = FETCH;
            mem_rd_d = 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_rd_q     <= 1'b0;
      fetch_addr_q <= '0;
      shift_word_q <= '0;
      pix_valid_q  <= 1'b0;
`ifdef SCREEN_READER_PREFETCH_EN
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_rd_q     <= mem_rd_d;
      fetch_addr_q <= fetch_addr_d;
      shift_word_q <= shift_word_d;
      pix_valid_q  <= pix_valid_d;
`ifdef SCREEN_READER_PREFETCH_EN
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
`endif
    end
  end

  pixel_serializer u_ser (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .data    (load_data),
    .advance (advance),
    .bit_out (ser_bit),
    .first   (ser_first),
    .last    (ser_last)
  );

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = fetch_addr_q;
  assign pix         = ser_bit;
  assign pix_valid   = pix_valid_q;
  assign line_start  = pix_valid_q && ser_first && ((32'(shift_word_q) % WORDS_PER_LINE) == 0);
  assign frame_start = pix_valid_q && ser_first && (shift_word_q == '0);

endmodule
